// File: rtl/lsu_mem_master_if.sv
// Shared load/store types and the bundled request/response/memory port of the
// load/store initiator. The master modport is the initiator's view. The slave
// modport is the view of the core and the data memory together.
package lsu_pkg;
  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    RAM_MASK_B = 2'd0,
    RAM_MASK_H = 2'd1,
    RAM_MASK_W = 2'd2
  } ram_mask_e;
endpackage

interface lsu_mem_master_if #(parameter int ADDR_LENGTH = 21);
  import lsu_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [31:0]            req_addr;
  logic [31:0]            req_wdata;
  mem_op_e                req_mem_op;
  ram_mask_e              req_mask;
  logic                   req_unsigned;

  logic                   rsp_valid;
  logic [31:0]            rsp_rdata;

  logic [ADDR_LENGTH-3:0] mem_addr;
  logic                   mem_re;
  logic                   mem_we;
  logic [3:0]             mem_be;
  logic [31:0]            mem_wdata;
  logic [31:0]            mem_rdata;

  modport master (
    input  req_valid, req_addr, req_wdata, req_mem_op, req_mask, req_unsigned, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_re, mem_we, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_mem_op, req_mask, req_unsigned, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_re, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns one byte/halfword/word request into one or two
// aligned, byte-enabled beats on a synchronous memory with one-cycle read
// latency. It then assembles and extends the load data.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_LENGTH = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  lsu_mem_master_if.master bus
);
  localparam int AW = ADDR_LENGTH - 2;

  typedef enum logic [1:0] {IDLE, B0, B1, DONE} state_e;

  typedef struct packed {
    logic [1:0]    off;
    logic [AW-1:0] w0;
    logic [31:0]   wdata;
    logic          is_load;
    logic [2:0]    nbytes;
    logic          uns;
  } req_t;

  state_e        state_q, state_d;
  req_t          cur_q;
  logic [31:0]   lo_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;

  logic          accept, req_is_load, req_is_store, split, rsp_fire;
  logic [2:0]    req_nbytes;
  logic [7:0]    lane_m;
  logic [63:0]   lane_d, rd_pair;
  logic [31:0]   rd_shift, rd_result;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[31:ADDR_LENGTH];

  // Decode the request offered on the port.
  always_comb begin
    req_is_load  = (bus.req_mem_op == MEM_LOAD);
    req_is_store = (bus.req_mem_op == MEM_STORE);
    case (bus.req_mask)
      RAM_MASK_B: req_nbytes = 3'd1;
      RAM_MASK_H: req_nbytes = 3'd2;
      default:    req_nbytes = 3'd4;
    endcase
    accept = (state_q == IDLE) && bus.req_valid;
  end

  // Lane mask and lane-shifted store data spanning two words (low word = beat 0).
  assign split  = ({1'b0, cur_q.off} + cur_q.nbytes) > 3'd4;
  assign lane_m = ((8'd1 << cur_q.nbytes) - 8'd1) << cur_q.off;
  assign lane_d = {32'd0, cur_q.wdata} << {cur_q.off, 3'b000};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and memory beat outputs; the bus is idle outside B0/B1.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d       = state_q;
    bus.mem_addr  = '0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'h0;
    bus.mem_wdata = 32'h0;
    case (state_q)
      IDLE: if (accept && (req_is_load || req_is_store)) state_d = B0;
      B0: begin
        bus.mem_addr  = cur_q.w0;
        bus.mem_be    = lane_m[3:0];
        bus.mem_wdata = lane_d[31:0];
        bus.mem_re    = cur_q.is_load;
        bus.mem_we    = !cur_q.is_load;
        if (split)              state_d = B1;
        else if (cur_q.is_load) state_d = DONE;
        else                    state_d = IDLE;
      end
      B1: begin
        bus.mem_addr  = cur_q.w0 + AW'(1);
        bus.mem_be    = lane_m[7:4];
        bus.mem_wdata = lane_d[63:32];
        bus.mem_re    = cur_q.is_load;
        bus.mem_we    = !cur_q.is_load;
        state_d       = cur_q.is_load ? DONE : IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load assembly: in DONE the last beat's data is on mem_rdata. The low word
  // comes from lo_q only when the access was split.
  always_comb begin
    rsp_fire = ((state_q != IDLE) && (state_d == IDLE)) ||
               (accept && !req_is_load && !req_is_store);
    rd_pair  = {bus.mem_rdata, split ? lo_q : bus.mem_rdata};
    rd_shift = 32'(rd_pair >> {cur_q.off, 3'b000});
    case (cur_q.nbytes)
      3'd1:    rd_result = cur_q.uns ? {24'd0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'd2:    rd_result = cur_q.uns ? {16'd0, rd_shift[15:0]}
                                     : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: rd_result = rd_shift;
    endcase
  end

  // Request capture, low-word load capture and the registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q       <= '0;
      lo_q        <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values.
      if (accept) begin
        cur_q <= '{off:     bus.req_addr[1:0],
                   w0:      bus.req_addr[ADDR_LENGTH-1:2],
                   wdata:   bus.req_wdata,
                   is_load: req_is_load,
                   nbytes:  req_nbytes,
                   uns:     bus.req_unsigned};
      end
      if ((state_q == B1) && cur_q.is_load) lo_q <= bus.mem_rdata;
      rsp_valid_q <= rsp_fire;
      if (rsp_fire) rsp_rdata_q <= (state_q == DONE) ? rd_result : 32'h0;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Testbench for lsu_mem_master. It issues directed and random requests.
// A byte-level reference model predicts the memory beats and responses,
// and independent monitors compare them against the DUT.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  localparam int          AL    = 21;
  localparam int          AW    = AL - 2;
  localparam logic [31:0] AMASK = (32'd1 << AL) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_master_if #(.ADDR_LENGTH(AL)) bus();

  lsu_mem_master #(.ADDR_LENGTH(AL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic          we;
    logic [31:0]   wdata;
  } beat_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
  } rsp_t;

  beat_t       beat_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] ram     [int unsigned];
  logic [31:0] ref_ram [int unsigned];
  logic [31:0] rd_next;
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dflt(input int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] ram_rd(input int unsigned w);
    return ram.exists(w) ? ram[w] : dflt(w);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned w);
    return ref_ram.exists(w) ? ref_ram[w] : dflt(w);
  endfunction

  // Synchronous memory responder: byte-enabled writes, read data one cycle after mem_re.
  always @(negedge clk) begin
    logic [31:0] w;
    if (bus.mem_we) begin
      w = ram_rd(int'(bus.mem_addr));
      for (int k = 0; k < 4; k++)
        if (bus.mem_be[k]) w[8*k +: 8] = bus.mem_wdata[8*k +: 8];
      ram[int'(bus.mem_addr)] = w;
    end
    rd_next = bus.mem_re ? ram_rd(int'(bus.mem_addr)) : $urandom;
  end
  always @(posedge clk) bus.mem_rdata <= rd_next;

  // Memory beat monitor.
  always @(negedge clk) begin
    beat_t       b;
    logic [31:0] lm;
    if (bus.mem_re || bus.mem_we) begin
      if (beat_q.size() == 0) begin
        check("beat_unexpected", {bus.mem_re, bus.mem_we}, 0);
      end else begin
        b = beat_q.pop_front();
        check("beat_cycle", cyc, b.cyc);
        check("beat_addr", bus.mem_addr, b.addr);
        check("beat_be", bus.mem_be, b.be);
        check("beat_we", bus.mem_we, b.we);
        check("beat_re", bus.mem_re, !b.we);
        if (b.we) begin
          for (int k = 0; k < 4; k++) lm[8*k +: 8] = {8{b.be[k]}};
          check("beat_wdata", bus.mem_wdata & lm, b.wdata);
        end
      end
    end else begin
      check("bus_idle_zero", {bus.mem_addr, bus.mem_be, bus.mem_wdata}, 0);
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    rsp_t r;
    if (bus.rsp_valid) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", bus.rsp_valid, 0);
      end else begin
        r = rsp_q.pop_front();
        check("rsp_cycle", cyc, r.cyc);
        check("rsp_rdata", bus.rsp_rdata, r.rdata);
        check("ready_at_rsp", bus.req_ready, 1);
      end
    end
  end

  // Reference model: walk the accessed bytes one at a time.
  task automatic model(input mem_op_e op, input ram_mask_e mk, input logic [31:0] addr,
                       input logic [31:0] wd, input logic uns, input int t);
    int unsigned ea, ba, w, lane;
    int          n, j, lat;
    logic        split, st;
    logic [31:0] val, word;
    beat_t       bt[2];
    if (op != MEM_LOAD && op != MEM_STORE) begin
      rsp_q.push_back('{cyc: t + 1, rdata: 32'h0});
      return;
    end
    st    = (op == MEM_STORE);
    ea    = addr & AMASK;
    n     = (mk == RAM_MASK_B) ? 1 : (mk == RAM_MASK_H) ? 2 : 4;
    split = ((ea % 4) + n) > 4;
    val   = 32'h0;
    for (int b = 0; b < 2; b++) begin
      bt[b].cyc   = t + 1 + b;
      bt[b].addr  = AW'((ea / 4) + b);
      bt[b].be    = 4'h0;
      bt[b].we    = st;
      bt[b].wdata = 32'h0;
    end
    for (int i = 0; i < n; i++) begin
      ba   = (ea + i) & AMASK;
      w    = ba / 4;
      lane = ba % 4;
      j    = (AW'(w) == bt[0].addr) ? 0 : 1;
      bt[j].be[lane] = 1'b1;
      if (st) begin
        bt[j].wdata[8*lane +: 8] = wd[8*i +: 8];
        word = ref_rd(w);
        word[8*lane +: 8] = wd[8*i +: 8];
        ref_ram[w] = word;
      end else begin
        word = ref_rd(w);
        val[8*i +: 8] = word[8*lane +: 8];
      end
    end
    if (!st && !uns && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
    beat_q.push_back(bt[0]);
    if (split) beat_q.push_back(bt[1]);
    lat = st ? (split ? 3 : 2) : (split ? 4 : 3);
    rsp_q.push_back('{cyc: t + lat, rdata: st ? 32'h0 : val});
  endtask

  task automatic preload(input int unsigned w, input logic [31:0] v);
    ram[w]     = v;
    ref_ram[w] = v;
  endtask

  // Offer a request from the next falling edge and hold it until accepted.
  // Leaves req_valid high so a following call can issue back-to-back.
  task automatic issue(input mem_op_e op, input ram_mask_e mk, input logic [31:0] addr,
                       input logic [31:0] wd, input logic uns,
                       output int t, output logic rsp_seen);
    int guard = 0;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_mem_op   = op;
    bus.req_mask     = mk;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_unsigned = uns;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", bus.req_ready, 1);
    t        = cyc;
    rsp_seen = bus.rsp_valid;
    model(op, mk, addr, wd, uns, t);
  endtask

  task automatic drop();
    @(negedge clk);
    bus.req_valid    = 1'b0;
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    bus.req_mem_op   = mem_op_e'(2'($urandom_range(0, 3)));
    bus.req_mask     = ram_mask_e'(2'($urandom_range(0, 3)));
    bus.req_unsigned = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int guard = 0;
    while ((rsp_q.size() != 0 || beat_q.size() != 0) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("drain_rsp", rsp_q.size(), 0);
    check("drain_beats", beat_q.size(), 0);
  endtask

  initial begin
    int          t;
    logic        seen;
    int          guard;
    mem_op_e     op;
    ram_mask_e   mk;
    logic [31:0] a;

    bus.req_valid    = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_mem_op   = MEM_NOP;
    bus.req_mask     = RAM_MASK_W;
    bus.req_unsigned = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset_ready", bus.req_ready, 1);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_rdata", bus.rsp_rdata, 0);
    check("reset_mem_strobes", {bus.mem_re, bus.mem_we}, 0);
    check("reset_mem_bus", {bus.mem_addr, bus.mem_be, bus.mem_wdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Aligned LW.
    preload(32'h40, 32'hDEAD_BEEF);
    issue(MEM_LOAD, RAM_MASK_W, 32'h100, $urandom, 1'b0, t, seen);
    drop();
    drain();

    // Split SW.
    issue(MEM_STORE, RAM_MASK_W, 32'h103, 32'h1122_3344, 1'b0, t, seen);
    drop();
    drain();

    // Split LH, signed then unsigned, back-to-back.
    preload(32'h1, 32'h8000_0000);
    preload(32'h2, 32'h0000_00FF);
    issue(MEM_LOAD, RAM_MASK_H, 32'h7, $urandom, 1'b0, t, seen);
    issue(MEM_LOAD, RAM_MASK_H, 32'h7, $urandom, 1'b1, t, seen);
    drop();
    drain();

    // Wrap from the top word to word 0, then read it back with junk upper address bits.
    issue(MEM_STORE, RAM_MASK_W, 32'h001F_FFFE, 32'hCAFE_F00D, 1'b0, t, seen);
    issue(MEM_LOAD, RAM_MASK_W, 32'hABE0_0000 | 32'h001F_FFFE, $urandom, 1'b0, t, seen);
    drop();
    drain();

    // Back-to-back LB, then a no-op.
    preload(32'h40, 32'h00A5_0000);
    issue(MEM_LOAD, RAM_MASK_B, 32'h102, $urandom, 1'b0, t, seen);
    issue(MEM_LOAD, RAM_MASK_B, 32'h102, $urandom, 1'b1, t, seen);
    check("b2b_accept_with_rsp", seen, 1);
    issue(MEM_NOP, RAM_MASK_W, 32'h104, $urandom, 1'b0, t, seen);
    drop();
    drain();

    // Reset in the middle of a split load (during B1).
    issue(MEM_LOAD, RAM_MASK_H, 32'h7, $urandom, 1'b0, t, seen);
    drop();
    guard = 0;
    while (cyc < t + 2 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_strobes", {bus.mem_re, bus.mem_we}, 0);
    check("abort_mem_bus", {bus.mem_addr, bus.mem_be, bus.mem_wdata}, 0);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    beat_q.delete();
    rsp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after_release", bus.req_ready, 1);
    repeat (6) @(negedge clk);

    // Random traffic near word 0 and near the top of the address space.
    for (int i = 0; i < 300; i++) begin
      op = mem_op_e'(2'($urandom_range(0, 3)));
      mk = ram_mask_e'(2'($urandom_range(0, 3)));
      a  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 47))
                                       : AMASK - 32'($urandom_range(0, 47));
      a  = ($urandom & ~AMASK) | a;
      issue(op, mk, a, $urandom, 1'($urandom_range(0, 1)), t, seen);
      if ($urandom_range(0, 2) == 0) begin
        drop();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drop();
    drain();

    // Final memory contents against the model.
    foreach (ref_ram[k]) check("ram_word", ram_rd(k), ref_ram[k]);
    foreach (ram[k]) if (!ref_ram.exists(k)) check("ram_extra_word", ram[k], dflt(k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator between the rv32i core's memory stage and a word-wide, byte-enabled synchronous data memory. It accepts one byte, halfword or word request at a time. Accesses that cross a word boundary are split into two aligned memory beats. Write data is placed on the correct byte lanes, and read data is assembled with sign or zero extension. It is the requesting end of the memory port, replacing direct combinational byte-lane access so that block-RAM with one-cycle read latency can be used.

## Interface
- `ADDR_LENGTH`, 21, byte-address bits decoded; memory word address width is `ADDR_LENGTH-2`.

- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept; equals (state == IDLE).
- `req_addr` in 32: byte address; bits above `ADDR_LENGTH-1` are ignored.
- `req_wdata` in 32: store data, right-justified.
- `req_mem_op` in `mem_op_e`: `MEM_LOAD`, `MEM_STORE`; any other value is a no-op.
- `req_mask` in `ram_mask_e`: `RAM_MASK_B`=1 byte, `RAM_MASK_H`=2 bytes, `RAM_MASK_W` or other=4 bytes.
- `req_unsigned` in 1: loads zero-extend when 1, sign-extend when 0.
- `rsp_valid` out 1: registered one-cycle completion pulse.
- `rsp_rdata` out 32: load result; 0 for stores and no-ops; held until next `rsp_valid`.
- `mem_addr` out `ADDR_LENGTH-2`: word address.
- `mem_re` out 1: read strobe; data returns on `mem_rdata` the following cycle.
- `mem_we` out 1: write strobe, qualified by `mem_be`.
- `mem_be` out 4: byte enables; bit k selects `mem_wdata[8k+7:8k]`, little-endian.
- `mem_wdata` out 32: lane-aligned write data.
- `mem_rdata` in 32: read data, valid the cycle after `mem_re`.

## Operation
- FSM states: IDLE, B0, B1, DONE.
- **Accept:** in IDLE with `req_valid`=1, capture addr/wdata/op/mask/unsigned. `req_*` are ignored at all other times.
- **Setup values:** off = addr[1:0]; n = 1, 2 or 4 bytes; split = (off + n > 4); w0 = addr[ADDR_LENGTH-1:2]; w1 = w0+1 modulo 2^(ADDR_LENGTH-2), so the top word wraps to word 0.
- **Transitions:**
  - IDLE → B0 for a load or store.
  - IDLE stays IDLE for a no-op, with `rsp_valid` pulsed next cycle and rdata 0.
  - B0 → B1 if split.
  - B0 → DONE for an unsplit load.
  - B0 → IDLE for an unsplit store, pulsing `rsp_valid`.
  - B1 → DONE for a load.
  - B1 → IDLE for a store, pulsing `rsp_valid`.
  - DONE → IDLE, pulsing `rsp_valid` with the assembled data.
- **Lane mask:** m = ((1<<n)-1) << off, 8 bits.
  - B0: addr=w0, be=m[3:0], wdata=(wdata << 8·off)[31:0].
  - B1: addr=w1, be=m[7:4], wdata=wdata >> 8·(4−off).
- **Strobes:** `mem_re` or `mem_we` is asserted only in B0/B1, per op. In IDLE and DONE all `mem_*` outputs are 0.
- **Load capture and assembly:**
  - Capture `mem_rdata` into lo the cycle after B0, and into hi the cycle after B1.
  - Result = ({hi,lo} >> 8·off), truncated to n bytes, then extended per `req_unsigned`. hi is unused when not split.
- **Back-to-back:** state is IDLE in the `rsp_valid` cycle, so a new request may be accepted in that cycle.

## Timing
- **Reset value (async, immediate):** state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, all `mem_*`=0.
- **Latency** (accept at cycle T; `rsp_valid` cycle):
  - unsplit store: T+2
  - split store: T+3
  - unsplit load: T+3
  - split load: T+4
  - no-op: T+1
- **Memory beats:** B0 at T+1, B1 at T+2.
- **Throughput:** at most one outstanding request. Ready is low from T+1 until the `rsp_valid` cycle.
- **Reset mid-operation:** the transaction is aborted. No further strobes and no `rsp_valid` are produced, and `req_ready`=1 in the first cycle after release.

## Test plan
- **Aligned LW:** addr 0x100, memory word 0x40=0xDEADBEEF → T+1 re=1 addr 0x40 be 0xF; T+3 rsp_valid, rdata 0xDEADBEEF.
- **Split SW:** addr 0x103, wdata 0x11223344 → T+1 we addr 0x40 be 0x8 wdata[31:24]=0x44; T+2 we addr 0x41 be 0x7 wdata[23:0]=0x112233; T+3 rsp_valid, rdata 0.
- **Split LH:** addr 0x7, word1=0x80000000, word2=0x000000FF → beats at 0x1 then 0x2, both be pattern 0x8/0x1; signed result 0xFFFFFF80 at T+4; unsigned result 0x0000FF80.
- **Wrap:** ADDR_LENGTH=21, SW at 0x1FFFFE → B0 addr 0x7FFFF be 0xC; B1 addr 0x00000 be 0x3.
- **Back-to-back:** `req_valid` held for LB 0x102 then LB 0x102 unsigned, word 0x00A50000 → rdata 0xFFFFFFA5 then 0x000000A5; second accept coincides with the first `rsp_valid`; no-op request → `rsp_valid` at T+1 with no `mem_*` activity.
- **Reset abort:** `rst_n` low at T+2 of a split load → `mem_*` and `rsp_valid` go 0 immediately; after release, no response and `req_ready`=1.
